divider_seq_ctrl: RTL and testbench

Sequential front/back-end for the combinational unsigned 32-bit array divider (divider_32). It accepts signed or unsigned operands over a valid/ready handshake and registers the divider inputs. It converts signed operands to magnitudes, waits a fixed number of settle cycles for the array's multicycle path, then restores signs. It holds the registered quotient/remainder until downstream accepts them. It also handles divide-by-zero without using the array.

---
 rtl/divider_seq_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_divider_seq_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/divider_seq_ctrl.sv
// -----------------------------------------------------------------------------
// divider_seq_ctrl
//
// Purpose:
//   Sequential wrapper around a combinational unsigned 32-bit array divider.
//   - Accepts signed or unsigned operands over a valid/ready handshake.
//   - Converts signed operands to magnitudes and registers them as the array
//     inputs.
//   - Waits CALC_CYCLES edges for the array's multicycle path to settle.
//   - Restores the result signs and holds the result until downstream
//     accepts it.
//   - Divide-by-zero is answered directly, without using the array.
//
// Parameters:
//   CALC_CYCLES  settle cycles allowed for the array after its inputs are
//                registered (1..15)
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        synchronous active-high reset
//   in_valid     operand request valid
//   in_ready     block can accept a request (high only in IDLE)
//   a, b         dividend, divisor
//   is_signed    1 = two's-complement division, 0 = unsigned
//   out_valid    result valid (high only in DONE)
//   out_ready    downstream accepts result
//   q, rem       quotient, remainder
//   div_by_zero  result came from a zero divisor; qualified by out_valid
// -----------------------------------------------------------------------------
module divider_seq_ctrl #(
    parameter int CALC_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_signed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] q,
    output logic [31:0] rem,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] COUNT_LOAD = 4'(CALC_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_count;
    logic        r_sign_a;
    logic        r_sign_b;
    logic [31:0] r_mag_a;
    logic [31:0] r_mag_b;
    logic [31:0] r_q;
    logic [31:0] r_rem;
    logic        r_dbz;

    logic        w_accept;
    logic        w_sign_a;
    logic        w_sign_b;
    logic [31:0] w_q_arr;
    logic [31:0] w_rem_arr;

    // -------------------------------------------------------------------------
    // Combinational restoring array divider.
    // It is driven only from r_mag_a / r_mag_b, so its multicycle path starts
    // at registers. Each stage shifts in one dividend bit (MSB first) and
    // subtracts the divisor when that does not borrow.
    // -------------------------------------------------------------------------
    logic [31:0] w_part_rem [0:32];

    assign w_part_rem[0] = 32'd0;

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_div_stage
            logic [32:0] w_partial;
            logic [32:0] w_diff;

            assign w_partial = {w_part_rem[gi], r_mag_a[31-gi]};
            assign w_diff    = w_partial - {1'b0, r_mag_b};

            // The partial remainder is always below twice the divisor, so
            // bit 32 of the difference is set exactly when the subtraction
            // borrows.
            assign w_q_arr[31-gi]    = ~w_diff[32];
            assign w_part_rem[gi+1]  = w_diff[32] ? w_partial[31:0] : w_diff[31:0];
        end
    endgenerate

    assign w_rem_arr = w_part_rem[32];

    // -------------------------------------------------------------------------
    // Handshake and FSM
    // -------------------------------------------------------------------------
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_sign_a  = a[31] & is_signed;
    assign w_sign_b  = b[31] & is_signed;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_next = (b == 32'd0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (r_count == 4'd0) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= 4'd0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_mag_a  <= 32'd0;
            r_mag_b  <= 32'd0;
            r_q      <= 32'd0;
            r_rem    <= 32'd0;
            r_dbz    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sign_a <= w_sign_a;
                r_sign_b <= w_sign_b;
                if (b == 32'd0) begin
                    // The dividend is returned raw, even in signed mode.
                    r_q   <= 32'hFFFF_FFFF;
                    r_rem <= a;
                    r_dbz <= 1'b1;
                end else begin
                    r_mag_a <= w_sign_a ? (~a + 32'd1) : a;
                    r_mag_b <= w_sign_b ? (~b + 32'd1) : b;
                    r_count <= COUNT_LOAD;
                end
            end

            if (r_state == CALC) begin
                if (r_count == 4'd0) begin
                    // The quotient sign is the XOR of the operand signs.
                    // The remainder follows the dividend's sign.
                    r_q   <= (r_sign_a ^ r_sign_b) ? (~w_q_arr + 32'd1) : w_q_arr;
                    r_rem <= r_sign_a ? (~w_rem_arr + 32'd1) : w_rem_arr;
                    r_dbz <= 1'b0;
                end else begin
                    r_count <= r_count - 4'd1;
                end
            end
        end
    end

    assign q           = r_q;
    assign rem         = r_rem;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_divider_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_divider_seq_ctrl
//
// Directed, table-driven bench for divider_seq_ctrl with CALC_CYCLES = 2.
// The multi-cycle corner cases have hand-written sequences:
//   - backpressure on the result
//   - reset in the middle of an operation
// -----------------------------------------------------------------------------
module tb_divider_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        is_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] q;
    logic [31:0] rem;
    logic        div_by_zero;

    int checks;
    int failures;

    divider_seq_ctrl #(.CALC_CYCLES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .is_signed   (is_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .q           (q),
        .rem         (rem),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [31:0] q;
        logic [31:0] rem;
        logic        dbz;
        logic [3:0]  lat;
    } vec_t;

    vec_t vecs [0:11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one request with out_ready held high.
    // Checks latency, result and the consume that follows.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic ts, input logic [31:0] eq,
                          input logic [31:0] er, input logic ed,
                          input int elat, input string tag);
        int lat;
        @(negedge clk);
        a         = ta;
        b         = tb_v;
        is_signed = ts;
        in_valid  = 1'b1;
        chk({tag, " in_ready_before"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);          // accept edge
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: out_valid never rose within %0d edges", tag, lat);
            return;
        end
        chk({tag, " latency"}, 32'(lat), 32'(elat));
        chk({tag, " q"}, q, eq);
        chk({tag, " rem"}, rem, er);
        chk({tag, " dbz"}, {31'd0, div_by_zero}, {31'd0, ed});
        $display("op %s a=%h b=%h s=%0d -> q=%h rem=%h dbz=%0d lat=%0d",
                 tag, ta, tb_v, ts, q, rem, div_by_zero, lat);
        @(posedge clk);          // consume edge
        #1;
        chk({tag, " out_valid_after_consume"}, {31'd0, out_valid}, 32'd0);
        chk({tag, " in_ready_after_consume"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] hq;
        logic [31:0] hrem;
        logic        hdbz;
        int          seen_valid;
        int          lat;

        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = 32'd0;
        b         = 32'd0;
        is_signed = 1'b0;
        out_ready = 1'b1;

        //           a              b              sgn   q              rem            dbz   lat
        vecs[0]  = '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         1'b0, 4'd3};
        vecs[1]  = '{32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 4'd3};
        vecs[2]  = '{32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,         1'b0, 4'd3};
        vecs[3]  = '{32'h0000_1234, 32'd0,         1'b0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 4'd1};
        vecs[4]  = '{32'h0000_1234, 32'd0,         1'b1, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 4'd1};
        vecs[5]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,         1'b0, 4'd3};
        vecs[6]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,         32'h8000_0000, 1'b0, 4'd3};
        vecs[7]  = '{32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14,        32'hFFFF_FFFE, 1'b0, 4'd3};
        vecs[8]  = '{32'hFFFF_FFF9, 32'd2,         1'b0, 32'h7FFF_FFFC, 32'd1,         1'b0, 4'd3};
        vecs[9]  = '{32'hFFFF_FFF9, 32'd0,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 4'd1};
        vecs[10] = '{32'hFFFF_FFFF, 32'd1,         1'b0, 32'hFFFF_FFFF, 32'd0,         1'b0, 4'd3};
        vecs[11] = '{32'd3,         32'd10,        1'b1, 32'd0,         32'd3,         1'b0, 4'd3};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset q", q, 32'd0);
        chk("reset rem", rem, 32'd0);
        chk("reset dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // in_valid is low in IDLE, so nothing should be accepted.
        repeat (3) @(posedge clk);
        #1;
        chk("idle no accept", {31'd0, out_valid}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].q, vecs[i].rem,
                   vecs[i].dbz, int'(vecs[i].lat), $sformatf("vec%0d", i));
        end

        // Backpressure: hold the result for 5 cycles while a competing
        // request is presented.
        out_ready = 1'b0;
        @(negedge clk);
        a = 32'd1000; b = 32'd3; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("bp out_valid", {31'd0, out_valid}, 32'd1);
        chk("bp q", q, 32'd333);
        chk("bp rem", rem, 32'd1);
        hq = 32'd333; hrem = 32'd1; hdbz = 1'b0;
        @(negedge clk);
        a = 32'd7; b = 32'd1; is_signed = 1'b1; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp hold%0d q", c), q, hq);
            chk($sformatf("bp hold%0d rem", c), rem, hrem);
            chk($sformatf("bp hold%0d dbz", c), {31'd0, div_by_zero}, {31'd0, hdbz});
            chk($sformatf("bp hold%0d in_ready", c), {31'd0, in_ready}, 32'd0);
            chk($sformatf("bp hold%0d out_valid", c), {31'd0, out_valid}, 32'd1);
        end
        $display("op backpressure a=%h b=%h -> q=%h rem=%h held 5 cycles", 32'd1000, 32'd3, q, rem);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp consume out_valid", {31'd0, out_valid}, 32'd0);
        chk("bp consume in_ready", {31'd0, in_ready}, 32'd1);
        run_op(32'd9, 32'd4, 1'b0, 32'd2, 32'd1, 1'b0, 3, "after_bp");

        // Reset while in CALC. The previous result (q=2, rem=1) must be
        // cleared, and no result may appear later.
        @(negedge clk);
        a = 32'd81; b = 32'd9; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst q", q, 32'd0);
        chk("midrst rem", rem, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen_valid = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid++;
        end
        chk("midrst no late result", 32'(seen_valid), 32'd0);
        $display("op reset_mid_calc a=%h b=%h -> discarded", 32'd81, 32'd9);
        run_op(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0, 3, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog, so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
